fetch_prefetch: RTL and testbench

Parametrised next-generation instruction FETCH unit. Wishbone pipelined read master with up to G_DEPTH requests in flight, unlike the single-outstanding FETCH. Read responses go into a prefetch FIFO and are presented to DECODE through a valid/ready handshake. A new PC from DECODE flushes the FIFO, aborts the bus cycle and restarts fetching at the new address.

---
 rtl/fetch_prefetch.sv | 196 +++++++++++++++++++
 tb/tb_fetch_prefetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: pipelined Wishbone instruction fetch with a prefetch FIFO feeding DECODE.
// Optional error response path is enabled by defining FETCH_ERR_EN.
module fetch_prefetch #(
    parameter int unsigned G_ADDR_SIZE = 16,
    parameter int unsigned G_DATA_SIZE = 16,
    parameter int unsigned G_DEPTH     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   wb_cyc_o,
    output logic                   wb_stb_o,
    input  logic                   wb_stall_i,
    output logic [G_ADDR_SIZE-1:0] wb_addr_o,
    input  logic                   wb_ack_i,
    input  logic [G_DATA_SIZE-1:0] wb_data_i,
`ifdef FETCH_ERR_EN
    input  logic                   wb_err_i,
    output logic                   dc_err_o,
`endif
    output logic                   dc_valid_o,
    input  logic                   dc_ready_i,
    output logic [G_ADDR_SIZE-1:0] dc_addr_o,
    output logic [G_DATA_SIZE-1:0] dc_data_o,
    input  logic                   dc_valid_i,
    input  logic [G_ADDR_SIZE-1:0] dc_addr_i
);

    localparam int unsigned PTR_W = $clog2(G_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN} state_t;

    state_t                 r_state;
    logic [G_ADDR_SIZE-1:0] r_req_pc;
    logic [G_ADDR_SIZE-1:0] r_rsp_pc;
    logic [CNT_W-1:0]       r_out;
    logic [CNT_W-1:0]       r_count;
    logic [PTR_W-1:0]       r_rd;
    logic [PTR_W-1:0]       r_wr;
    logic [G_ADDR_SIZE-1:0] r_mem_addr [G_DEPTH];
    logic [G_DATA_SIZE-1:0] r_mem_data [G_DEPTH];
`ifdef FETCH_ERR_EN
    logic                   r_mem_err  [G_DEPTH];
    logic                   r_err_block;
`endif

    logic                   w_run;
    logic                   w_accept;
    logic                   w_rsp_in;
    logic                   w_resp;
    logic                   w_err;
    logic                   w_block;
    logic                   w_pop;
    logic                   w_credit;
    logic                   w_issue;
    logic [CNT_W-1:0]       w_out_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [CNT_W-1:0]       w_remain;
    logic [PTR_W-1:0]       w_rd_next;
    logic [G_DATA_SIZE-1:0] w_push_data;

    assign wb_addr_o = r_req_pc;
    assign w_run     = (r_state == S_RUN);
    assign w_accept  = wb_stb_o && !wb_stall_i;
    assign w_pop     = dc_valid_o && dc_ready_i;

`ifdef FETCH_ERR_EN
    assign w_rsp_in = wb_ack_i || wb_err_i;
    assign w_err    = w_resp && wb_err_i;
    assign w_block  = r_err_block || w_err;
`else
    assign w_rsp_in = wb_ack_i;
    assign w_err    = 1'b0;
    assign w_block  = 1'b0;
`endif

    // Responses are stored only while something is in flight and no redirect is arriving.
    assign w_resp      = w_run && !dc_valid_i && w_rsp_in && (r_out != '0);
    assign w_push_data = w_err ? '0 : wb_data_i;

    assign w_out_next = r_out + CNT_W'(w_accept) - CNT_W'(w_resp);
    assign w_cnt_next = r_count + CNT_W'(w_resp) - CNT_W'(w_pop);
    assign w_credit   = (SUM_W'(w_out_next) + SUM_W'(w_cnt_next)) < SUM_W'(G_DEPTH);
    assign w_issue    = w_credit && !w_block;
    assign w_rd_next  = r_rd + PTR_W'(w_pop);
    assign w_remain   = r_count - CNT_W'(w_pop);

    // FIFO storage, no reset needed: occupancy is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_resp) begin
            r_mem_addr[r_wr] <= r_rsp_pc;
            r_mem_data[r_wr] <= w_push_data;
`ifdef FETCH_ERR_EN
            r_mem_err[r_wr]  <= w_err;
`endif
        end
    end

    // Control FSM, bus request side and registered DECODE head.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            r_req_pc   <= '0;
            r_rsp_pc   <= '0;
            r_out      <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            dc_valid_o <= 1'b0;
            dc_addr_o  <= '0;
            dc_data_o  <= '0;
`ifdef FETCH_ERR_EN
            dc_err_o    <= 1'b0;
            r_err_block <= 1'b0;
`endif
        end else if (dc_valid_i) begin
            r_state    <= S_FLUSH;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            r_req_pc   <= dc_addr_i;
            r_rsp_pc   <= dc_addr_i;
            r_out      <= '0;
            r_count    <= '0;
            r_rd       <= '0;
            r_wr       <= '0;
            dc_valid_o <= 1'b0;
`ifdef FETCH_ERR_EN
            dc_err_o    <= 1'b0;
            r_err_block <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_IDLE;
                end
                S_FLUSH: begin
                    r_state  <= S_RUN;
                    wb_stb_o <= 1'b1;
                    wb_cyc_o <= 1'b1;
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_req_pc <= r_req_pc + G_ADDR_SIZE'(1);
                    end
                    if (w_resp) begin
                        r_wr     <= r_wr + PTR_W'(1);
                        r_rsp_pc <= r_rsp_pc + G_ADDR_SIZE'(1);
                    end
                    r_rd     <= w_rd_next;
                    r_out    <= w_out_next;
                    r_count  <= w_cnt_next;
                    wb_stb_o <= w_issue;
                    wb_cyc_o <= w_issue || (w_out_next != '0);
`ifdef FETCH_ERR_EN
                    r_err_block <= w_block;
`endif
                    // Head comes from storage unless the FIFO drains, then from the incoming response.
                    if (w_remain != '0) begin
                        dc_valid_o <= 1'b1;
                        dc_addr_o  <= r_mem_addr[w_rd_next];
                        dc_data_o  <= r_mem_data[w_rd_next];
`ifdef FETCH_ERR_EN
                        dc_err_o   <= r_mem_err[w_rd_next];
`endif
                    end else if (w_resp) begin
                        dc_valid_o <= 1'b1;
                        dc_addr_o  <= r_rsp_pc;
                        dc_data_o  <= w_push_data;
`ifdef FETCH_ERR_EN
                        dc_err_o   <= w_err;
`endif
                    end else begin
                        dc_valid_o <= 1'b0;
`ifdef FETCH_ERR_EN
                        dc_err_o   <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The credit rule must make a push into a full FIFO impossible.
    assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_resp && !w_pop && (r_count == CNT_W'(G_DEPTH))));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (r_out <= CNT_W'(G_DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed and randomized checks of fetch_prefetch against a queue-based model
// of the bus slave, the in-flight requests and the prefetch FIFO contents.
module tb_fetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_stall_i;
    logic [15:0] wb_addr_o;
    logic        wb_ack_i;
    logic [15:0] wb_data_i;
    logic        dc_valid_o;
    logic        dc_ready_i;
    logic [15:0] dc_addr_o;
    logic [15:0] dc_data_o;
    logic        dc_valid_i;
    logic [15:0] dc_addr_i;
`ifdef FETCH_ERR_EN
    logic        wb_err_i;
    logic        dc_err_o;
`endif

    always #5 clk = ~clk;

    fetch_prefetch #(
        .G_ADDR_SIZE(16),
        .G_DATA_SIZE(16),
        .G_DEPTH    (DEPTH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_stall_i(wb_stall_i),
        .wb_addr_o (wb_addr_o),
        .wb_ack_i  (wb_ack_i),
        .wb_data_i (wb_data_i),
`ifdef FETCH_ERR_EN
        .wb_err_i  (wb_err_i),
        .dc_err_o  (dc_err_o),
`endif
        .dc_valid_o(dc_valid_o),
        .dc_ready_i(dc_ready_i),
        .dc_addr_o (dc_addr_o),
        .dc_data_o (dc_data_o),
        .dc_valid_i(dc_valid_i),
        .dc_addr_i (dc_addr_i)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_acc = 0;
    int n_err_seen = 0;

    // Model: 0 = no PC yet, 1 = redirect cycle, 2 = fetching
    int          phase = 0;
    logic [15:0] exp_req = 16'h0000;
    bit          err_block = 1'b0;
    logic [15:0] pend_q[$];
    logic [15:0] f_addr_q[$];
    logic [15:0] f_data_q[$];
    bit          f_err_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend_q.delete();
        f_addr_q.delete();
        f_data_q.delete();
        f_err_q.delete();
        err_block = 1'b0;
    endtask

    task automatic step(input bit stall, input bit ack_en, input bit rdy, input bit fl,
                        input logic [15:0] pc, input bit err_en);
        bit          exp_stb;
        bit          acc;
        bit          pop;
        bit          do_ack;
        bit          do_err;
        logic [15:0] a;
        @(negedge clk);
        if (phase != 2) begin
            check("cyc_off", 32'(wb_cyc_o), 32'(0));
            check("stb_off", 32'(wb_stb_o), 32'(0));
            check("dc_valid_off", 32'(dc_valid_o), 32'(0));
        end else begin
            exp_stb = ((pend_q.size() + f_addr_q.size()) < DEPTH) && !err_block;
            check("stb", 32'(wb_stb_o), 32'(exp_stb));
            check("cyc", 32'(wb_cyc_o), 32'(exp_stb || (pend_q.size() != 0)));
            if (wb_stb_o) check("wb_addr", 32'(wb_addr_o), 32'(exp_req));
            check("dc_valid", 32'(dc_valid_o), 32'(f_addr_q.size() != 0));
            if (f_addr_q.size() != 0) begin
                check("dc_addr", 32'(dc_addr_o), 32'(f_addr_q[0]));
                check("dc_data", 32'(dc_data_o), 32'(f_data_q[0]));
`ifdef FETCH_ERR_EN
                check("dc_err", 32'(dc_err_o), 32'(f_err_q[0]));
                if (dc_err_o && dc_valid_o) n_err_seen++;
`endif
            end
        end
        acc    = wb_stb_o && !stall;
        pop    = dc_valid_o && rdy;
        do_ack = ack_en && (pend_q.size() != 0);
        do_err = do_ack && err_en;
        wb_stall_i = stall;
        wb_ack_i   = do_ack && !do_err;
        if (do_ack && !do_err) wb_data_i = ~pend_q[0];
        else wb_data_i = 16'($urandom);
`ifdef FETCH_ERR_EN
        wb_err_i = do_err;
`endif
        dc_ready_i = rdy;
        dc_valid_i = fl;
        dc_addr_i  = pc;
        if (fl) begin
            phase   = 1;
            exp_req = pc;
            model_clear();
        end else if (phase == 1) begin
            phase = 2;
        end else if (phase == 2) begin
            if (pop && (f_addr_q.size() != 0)) begin
                void'(f_addr_q.pop_front());
                void'(f_data_q.pop_front());
                void'(f_err_q.pop_front());
                n_pop++;
            end
            if (do_ack) begin
                a = pend_q.pop_front();
                f_addr_q.push_back(a);
                f_data_q.push_back(do_err ? 16'h0000 : ~a);
                f_err_q.push_back(do_err);
                if (do_err) err_block = 1'b1;
            end
            if (acc) begin
                pend_q.push_back(exp_req);
                exp_req = exp_req + 16'h0001;
                n_acc++;
            end
        end
    endtask

    initial begin
        int p0;
        int a0;
        bit e;
        rst        = 1'b0;
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        wb_data_i  = 16'h0000;
        dc_ready_i = 1'b0;
        dc_valid_i = 1'b0;
        dc_addr_i  = 16'h0000;
`ifdef FETCH_ERR_EN
        wb_err_i   = 1'b0;
`endif
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_cyc", 32'(wb_cyc_o), 32'(0));
        check("rst_stb", 32'(wb_stb_o), 32'(0));
        check("rst_addr", 32'(wb_addr_o), 32'(0));
        check("rst_dc_valid", 32'(dc_valid_o), 32'(0));
        check("rst_dc_addr", 32'(dc_addr_o), 32'(0));
        check("rst_dc_data", 32'(dc_data_o), 32'(0));
`ifdef FETCH_ERR_EN
        check("rst_dc_err", 32'(dc_err_o), 32'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

        // Back-to-back streaming from 0x0100 with one-cycle ack latency
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
        p0 = n_pop;
        repeat (24) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("throughput", 32'(n_pop - p0), 32'(21));

        // DECODE stalled: credits cap the requests at DEPTH
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0);
        a0 = n_acc;
        repeat (12) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("credit_limit", 32'(n_acc - a0), 32'(DEPTH));
        check("hold_addr", 32'(dc_addr_o), 32'(16'h0100));
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Slave stall holds the request address at 0x0102
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        a0 = n_acc;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("stall_count", 32'(n_acc - a0), 32'(2));
        check("stall_addr", 32'(wb_addr_o), 32'(16'h0102));
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Redirect with three in flight, ack in the same cycle is dropped
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        check("inflight", 32'(pend_q.size()), 32'(3));
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'h2000, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

        // Address wrap at the top of the PC space
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        p0 = n_pop;
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        check("wrap_pops", 32'(n_pop - p0), 32'(5));

        // Asynchronous reset mid-stream
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_cyc", 32'(wb_cyc_o), 32'(0));
        check("arst_stb", 32'(wb_stb_o), 32'(0));
        check("arst_dc_valid", 32'(dc_valid_o), 32'(0));
        check("arst_addr", 32'(wb_addr_o), 32'(0));
        @(negedge clk);
        rst   = 1'b0;
        phase = 0;
        model_clear();
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

`ifdef FETCH_ERR_EN
        // Error response on 0x0103 blocks issue until the next redirect
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0);
        p0 = n_err_seen;
        repeat (14) begin
            e = 1'b0;
            if (pend_q.size() != 0) e = (pend_q[0] == 16'h0103);
            step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, e);
        end
        check("err_seen", 32'(n_err_seen - p0), 32'(1));
        check("err_no_stb", 32'(wb_stb_o), 32'(0));
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
`endif

        // Randomized traffic
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b0);
        repeat (3000) begin
`ifdef FETCH_ERR_EN
            e = ($urandom_range(0, 29) == 0);
`else
            e = 1'b0;
`endif
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom), e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
